ili_seq_ctrl: RTL and testbench
===============================

ILI_SEQ_CTRL -- requirements
Module: ili_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1_000_000: cycles allowed in RESET or INIT before a handshake timeout; legal range >= 2.
REQ-002 Parameter MAX_RETRY, default 3: timeouts tolerated before ERROR; legal range 0..15.
REQ-003 Parameter FRAME_W, default 16: width of the frame counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_ena_btn  input  1  start request, level input; only its rising edge acts.
REQ-007 i_stop  input  1  abort request, level-sensitive.
REQ-008 i_resets_sent  input  1  one-cycle done pulse from the reset/initial sequencer.
REQ-009 i_command_sent  input  1  one-cycle done pulse from the command sender, meaning the init list is complete.
REQ-010 i_frame_sent  input  1  one-cycle pulse per completed loop frame.
REQ-011 o_state_leds  output  2  state code: IDLE 00, RESET 10, INIT 01, LOOP 11, ERROR 00.
REQ-012 o_error  output  1  high only in ERROR.
REQ-013 o_reset_ini_ena  output  1  high only in RESET.
REQ-014 o_send_comm_ena  output  1  high in INIT and LOOP.
REQ-015 o_command  output  1  command set select: INI_COMM (0) in INIT, LOOP_COMM (1) in LOOP, 0 otherwise.
REQ-016 o_retry_cnt  output  4  number of timeouts taken in the current run.
REQ-017 o_frame_cnt  output  FRAME_W  number of frames completed in LOOP.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, RESET, INIT, LOOP and ERROR; an illegal encoding SHALL go to IDLE on the next cycle.
REQ-019 The outputs in REQ-011..015 SHALL be decoded combinationally from the state register only (Moore), so they are valid in the first cycle of each state.
REQ-020 Start edge: btn_rise = i_ena_btn AND NOT the value of i_ena_btn registered on the previous cycle; that register is cleared by reset.
REQ-021 Transition priority, highest first: rst; i_stop (any state other than IDLE goes to IDLE); then the per-state rules below.
REQ-022 IDLE -> RESET on btn_rise; on that edge, clear o_retry_cnt and o_frame_cnt.
REQ-023 RESET -> INIT on i_resets_sent.
REQ-024 INIT -> LOOP on i_command_sent.
REQ-025 LOOP: hold; o_frame_cnt += 1 on each i_frame_sent; it wraps from 2^FRAME_W-1 to 0 with no flag.
REQ-026 ERROR -> RESET on btn_rise, clearing o_retry_cnt and o_frame_cnt; otherwise hold.
REQ-027 Timeout counter: cleared on every state entry; increments each cycle while in RESET or INIT; a timeout fires in the cycle the counter equals TIMEOUT_CYC-1 and no done pulse is present.
REQ-028 On timeout, if o_retry_cnt < MAX_RETRY: o_retry_cnt += 1 and go to RESET, restarting the full sequence from either RESET or INIT; otherwise go to ERROR.
REQ-029 A done pulse arriving in the same cycle as a timeout SHALL win: take the normal transition, with no retry increment.
REQ-030 i_resets_sent outside RESET, i_command_sent outside INIT and i_frame_sent outside LOOP SHALL be ignored.
REQ-031 i_stop together with btn_rise in IDLE: stay in IDLE (stop wins).
REQ-032 o_retry_cnt and o_frame_cnt SHALL hold their values in IDLE and ERROR for debug readout.

Reset
REQ-033 While rst=1 at a clock edge, the following SHALL be cleared: state=IDLE, timeout counter=0, o_retry_cnt=0, o_frame_cnt=0, registered button=0.
REQ-034 During and after reset, all outputs SHALL read 0.
REQ-035 Reset asserted mid-operation (any state) SHALL take effect at the next edge, overriding every other input.

Verification (TIMEOUT_CYC=16, MAX_RETRY=2, FRAME_W=4)
REQ-036 Nominal run: btn rise; resets_sent at cycle 5; command_sent 7 cycles later. Required: leds 00->10->01->11; o_command=1 in LOOP; o_retry_cnt=0.
REQ-037 Retry path: no resets_sent for 16 cycles. Required: retry_cnt=1, RESET re-entered; a second silent window gives retry_cnt=2; a third gives ERROR with o_error=1, leds=00, retry_cnt holding 2.
REQ-038 Tie case: resets_sent arrives exactly at counter=15. Required: INIT, retry_cnt unchanged.
REQ-039 Frame count: 17 frame_sent pulses in LOOP. Required: o_frame_cnt=1 (wrapped); pulses in INIT are not counted.
REQ-040 Stop and restart: i_stop in LOOP gives IDLE with frame_cnt held; holding btn high gives no restart; release then press gives RESET with counters 0.
REQ-041 rst pulsed in INIT with i_command_sent high in the same cycle. Required: IDLE, all outputs 0.

Source files
------------

// File: rtl/ili_seq_ctrl_if.sv
// Control/status bundle between the display sequencer controller and its surroundings.
// The master side drives the requests and done pulses; the slave side is the controller.
interface ili_seq_ctrl_if #(
    parameter int unsigned FRAME_W = 16
) ();
    logic               i_ena_btn;
    logic               i_stop;
    logic               i_resets_sent;
    logic               i_command_sent;
    logic               i_frame_sent;
    logic [1:0]         o_state_leds;
    logic               o_error;
    logic               o_reset_ini_ena;
    logic               o_send_comm_ena;
    logic               o_command;
    logic [3:0]         o_retry_cnt;
    logic [FRAME_W-1:0] o_frame_cnt;

    modport master (
        output i_ena_btn, i_stop, i_resets_sent, i_command_sent, i_frame_sent,
        input  o_state_leds, o_error, o_reset_ini_ena, o_send_comm_ena, o_command,
        input  o_retry_cnt, o_frame_cnt
    );

    modport slave (
        input  i_ena_btn, i_stop, i_resets_sent, i_command_sent, i_frame_sent,
        output o_state_leds, o_error, o_reset_ini_ena, o_send_comm_ena, o_command,
        output o_retry_cnt, o_frame_cnt
    );
endinterface

// File: rtl/ili_seq_ctrl.sv
// Run controller for an ILI display: reset sequence, init command list, then frame loop,
// with per-phase handshake timeout, bounded retry and an error park state.
module ili_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned FRAME_W     = 16
) (
    input logic          clk,
    input logic          rst,
    ili_seq_ctrl_if.slave bus_io
);

    localparam int unsigned     TmoW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      MaxRetry = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReset = 3'd1,
        StInit  = 3'd2,
        StLoop  = 3'd3,
        StError = 3'd4
    } state_e;

    state_e             state_q;
    logic [TmoW-1:0]    tmo_q;
    logic [3:0]         retry_q;
    logic [FRAME_W-1:0] frame_q;
    logic               btn_q;

    logic btn_rise;
    logic tmo_hit;
    logic retry_ok;

    assign btn_rise = bus_io.i_ena_btn & ~btn_q;
    assign tmo_hit  = (tmo_q == TmoLast);
    assign retry_ok = (retry_q < MaxRetry);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tmo_q   <= '0;
            retry_q <= '0;
            frame_q <= '0;
            btn_q   <= 1'b0;
        end else begin
            btn_q <= bus_io.i_ena_btn;
            tmo_q <= '0;
            if (bus_io.i_stop && (state_q != StIdle)) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle, StError: begin
                        // Stop in IDLE suppresses a simultaneous start edge
                        if (btn_rise && !bus_io.i_stop) begin
                            state_q <= StReset;
                            retry_q <= '0;
                            frame_q <= '0;
                        end
                    end
                    StReset, StInit: begin
                        if ((state_q == StReset) ? bus_io.i_resets_sent
                                                 : bus_io.i_command_sent) begin
                            state_q <= (state_q == StReset) ? StInit : StLoop;
                        end else if (tmo_hit) begin
                            if (retry_ok) begin
                                state_q <= StReset;
                                retry_q <= retry_q + 4'd1;
                            end else begin
                                state_q <= StError;
                            end
                        end else begin
                            tmo_q <= tmo_q + TmoW'(1);
                        end
                    end
                    StLoop: begin
                        if (bus_io.i_frame_sent) begin
                            frame_q <= frame_q + FRAME_W'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        bus_io.o_state_leds    = 2'b00;
        bus_io.o_error         = 1'b0;
        bus_io.o_reset_ini_ena = 1'b0;
        bus_io.o_send_comm_ena = 1'b0;
        bus_io.o_command       = 1'b0;
        case (state_q)
            StReset: begin
                bus_io.o_state_leds    = 2'b10;
                bus_io.o_reset_ini_ena = 1'b1;
            end
            StInit: begin
                bus_io.o_state_leds    = 2'b01;
                bus_io.o_send_comm_ena = 1'b1;
            end
            StLoop: begin
                bus_io.o_state_leds    = 2'b11;
                bus_io.o_send_comm_ena = 1'b1;
                bus_io.o_command       = 1'b1;
            end
            StError: bus_io.o_error = 1'b1;
            default: ;
        endcase
    end

    assign bus_io.o_retry_cnt = retry_q;
    assign bus_io.o_frame_cnt = frame_q;

endmodule

// File: tb/tb_ili_seq_ctrl.sv
// Scoreboard bench for ili_seq_ctrl: directed scenarios then random traffic, checked against
// a cycle-level behavioural model of the run controller.
module tb_ili_seq_ctrl;

    localparam int TO = 16;
    localparam int MR = 2;
    localparam int FW = 4;

    localparam int M_IDLE = 0, M_RESET = 1, M_INIT = 2, M_LOOP = 3, M_ERROR = 4;

    typedef struct {
        logic [13:0] v;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    ili_seq_ctrl_if #(.FRAME_W(FW)) bus ();

    ili_seq_ctrl #(
        .TIMEOUT_CYC(TO),
        .MAX_RETRY  (MR),
        .FRAME_W    (FW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    string phase = "init";
    bit    drv_done = 0;

    // Behavioural model
    int m_st = M_IDLE, m_age = 0, m_retry = 0, m_frame = 0;
    bit m_btn = 0;

    function automatic logic [13:0] dut_vec();
        return {bus.o_state_leds, bus.o_error, bus.o_reset_ini_ena, bus.o_send_comm_ena,
                bus.o_command, bus.o_retry_cnt, bus.o_frame_cnt};
    endfunction

    function automatic logic [13:0] model_vec();
        logic [1:0] leds;
        logic       err, rie, sce, cmd;
        leds = 2'b00; err = 0; rie = 0; sce = 0; cmd = 0;
        if (m_st == M_RESET) begin leds = 2'b10; rie = 1; end
        if (m_st == M_INIT)  begin leds = 2'b01; sce = 1; end
        if (m_st == M_LOOP)  begin leds = 2'b11; sce = 1; cmd = 1; end
        if (m_st == M_ERROR) err = 1;
        return {leds, err, rie, sce, cmd, 4'(m_retry), 4'(m_frame)};
    endfunction

    task automatic model_step(input bit btn, stop, rs, cs, fs, r);
        bit rise, reentry, done;
        int nxt;
        rise    = btn && !m_btn;
        reentry = 0;
        if (r) begin
            m_st = M_IDLE; m_age = 0; m_retry = 0; m_frame = 0; m_btn = 0;
            return;
        end
        m_btn = btn;
        nxt   = m_st;
        if (stop && m_st != M_IDLE) begin
            nxt = M_IDLE;
        end else if (m_st == M_IDLE || m_st == M_ERROR) begin
            if (rise && !stop) begin
                nxt = M_RESET; m_retry = 0; m_frame = 0;
            end
        end else if (m_st == M_RESET || m_st == M_INIT) begin
            done = (m_st == M_RESET) ? rs : cs;
            if (done) nxt = m_st + 1;
            else if (m_age == TO - 1) begin
                if (m_retry < MR) begin
                    m_retry++; nxt = M_RESET; reentry = 1;
                end else nxt = M_ERROR;
            end
        end else if (m_st == M_LOOP && fs) begin
            m_frame = (m_frame + 1) % (1 << FW);
        end
        if (nxt != m_st || reentry) m_age = 0;
        else if (m_st == M_RESET || m_st == M_INIT) m_age++;
        m_st = nxt;
    endtask

    task automatic cyc(input bit btn, stop, rs, cs, fs, r);
        exp_t e;
        bus.i_ena_btn      = btn;
        bus.i_stop         = stop;
        bus.i_resets_sent  = rs;
        bus.i_command_sent = cs;
        bus.i_frame_sent   = fs;
        rst                = r;
        @(posedge clk);
        model_step(btn, stop, rs, cs, fs, r);
        e.v   = model_vec();
        e.tag = phase;
        sb.push_back(e);
        #1;
    endtask

    task automatic idle_n(input int n, input bit btn);
        for (int i = 0; i < n; i++) cyc(btn, 0, 0, 0, 0, 0);
    endtask

    // Direct checks against spec constants; sampled 1 time unit after the edge
    task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Monitor: pops one expected record per clock and compares mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (dut_vec() !== e.v) begin
                    bad++;
                    $display("FAIL sb_%s @%0t: got %b expected %b", e.tag, $time, dut_vec(), e.v);
                end
            end
        end
    end

    initial begin
        bus.i_ena_btn = 0; bus.i_stop = 0; bus.i_resets_sent = 0;
        bus.i_command_sent = 0; bus.i_frame_sent = 0; rst = 1;

        phase = "reset";
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("reset_outs", dut_vec(), 14'b0);

        phase = "nominal";
        cyc(1, 0, 0, 0, 0, 0);
        chk("enter_reset", dut_vec(), {2'b10, 4'b0100, 4'd0, 4'd0});
        idle_n(3, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("enter_init", dut_vec(), {2'b01, 4'b0010, 4'd0, 4'd0});
        cyc(0, 0, 0, 0, 1, 0);
        idle_n(5, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("enter_loop", dut_vec(), {2'b11, 4'b0011, 4'd0, 4'd0});

        phase = "frames";
        for (int i = 0; i < 17; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
        chk("frame_wrap", dut_vec(), {2'b11, 4'b0011, 4'd0, 4'd1});

        phase = "stop";
        cyc(1, 1, 0, 0, 0, 0);
        chk("stop_idle", dut_vec(), {2'b00, 4'b0000, 4'd0, 4'd1});
        idle_n(5, 1);
        chk("held_btn_idle", dut_vec(), {2'b00, 4'b0000, 4'd0, 4'd1});
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("restart", dut_vec(), {2'b10, 4'b0100, 4'd0, 4'd0});

        phase = "retry";
        idle_n(16, 0);
        chk("retry1", dut_vec(), {2'b10, 4'b0100, 4'd1, 4'd0});
        idle_n(16, 0);
        chk("retry2", dut_vec(), {2'b10, 4'b0100, 4'd2, 4'd0});
        idle_n(16, 0);
        chk("error", dut_vec(), {2'b00, 4'b1000, 4'd2, 4'd0});
        idle_n(20, 0);
        chk("error_hold", dut_vec(), {2'b00, 4'b1000, 4'd2, 4'd0});

        phase = "tie";
        cyc(1, 0, 0, 0, 0, 0);
        idle_n(15, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("tie_init", dut_vec(), {2'b01, 4'b0010, 4'd0, 4'd0});

        phase = "init_tmo";
        idle_n(16, 0);
        chk("init_timeout", dut_vec(), {2'b10, 4'b0100, 4'd1, 4'd0});

        phase = "rst_init";
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        chk("rst_in_init", dut_vec(), 14'b0);

        phase = "random";
        begin
            bit btn = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 9) == 0) btn = ~btn;
                cyc(btn,
                    $urandom_range(0, 59) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 299) == 0);
            end
        end

        drv_done = 1;
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
